// File: rtl/iter_shift_unit_pkg.sv
// Shared opcode, state and helper definitions for the iterative shift unit.
package iter_shift_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_SHR  = 3'd0;
  localparam op_t OP_SHRA = 3'd1;
  localparam op_t OP_SHL  = 3'd2;
  localparam op_t OP_ROR  = 3'd3;
  localparam op_t OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Legal opcodes are SHR through ROL; higher encodings raise illegal.
  function automatic logic op_is_legal(input op_t op);
    return (op <= OP_ROL);
  endfunction

  function automatic logic op_is_rotate(input op_t op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/iter_shift_unit_if.sv
// Request/response bundle between the control sequencer and the shift unit.
interface iter_shift_unit_if
  import iter_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  start;
  logic                  abort;
  op_t                   op;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] amount;
  logic                  busy;
  logic                  done;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, abort, op, operand, amount,
    input  busy, done, illegal, result
  );

  modport slave (
    input  start, abort, op, operand, amount,
    output busy, done, illegal, result
  );

endinterface

// File: rtl/iter_shift_unit_shift_step.sv
// One iteration of the shifter: moves data by k positions (0..STEP) per mode.
module iter_shift_unit_shift_step
  import iter_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  op_t                   mode,
  input  logic [CNT_W-1:0]      k,
  output logic [DATA_WIDTH-1:0] result_c
);

  logic [CNT_W-1:0] k_inv_c;

  // Complementary amount for the wrap-around half of a rotate.
  assign k_inv_c = CNT_W'(DATA_WIDTH) - k;

  // Mode-dependent shift of the accumulator.
  always_comb begin
    result_c = data;
    case (mode)
      OP_SHR:  result_c = data >> k;
      OP_SHRA: result_c = DATA_WIDTH'($signed(data) >>> k);
      OP_SHL:  result_c = data << k;
      OP_ROR:  result_c = (data >> k) | (data << k_inv_c);
      OP_ROL:  result_c = (data << k) | (data >> k_inv_c);
      default: result_c = data;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: SHR, SHRA, SHL, ROR, ROL with abort and illegal-op flag.
module iter_shift_unit
  import iter_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 1
) (
  input logic               clock,
  input logic               clear,
  iter_shift_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned ROT_W = $clog2(DATA_WIDTH);

  state_e                state;
  op_t                   mode;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      count;
  logic                  busy_q;
  logic                  done_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic                  accept_c;
  logic                  legal_c;
  logic [CNT_W-1:0]      n_c;
  logic [CNT_W-1:0]      k_c;
  logic [DATA_WIDTH-1:0] step_c;

  // Requests are taken in IDLE (unless aborted) and in DONE for back-to-back issue.
  assign accept_c = bus.start &&
                    (((state == S_IDLE) && !bus.abort) || (state == S_DONE));
  assign legal_c  = op_is_legal(bus.op);

  // Iteration count: shifts clamp at the width (saturation), rotates wrap.
  always_comb begin
    n_c = '0;
    if (op_is_rotate(bus.op)) begin
      n_c = CNT_W'(bus.amount[ROT_W-1:0]);
    end else if (bus.amount >= DATA_WIDTH'(DATA_WIDTH)) begin
      n_c = CNT_W'(DATA_WIDTH);
    end else begin
      n_c = CNT_W'(bus.amount[ROT_W-1:0]);
    end
  end

  // Positions moved this cycle: the smaller of STEP and what remains.
  assign k_c = (count > CNT_W'(STEP)) ? CNT_W'(STEP) : count;

  iter_shift_unit_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_shift_step (
    .data     (acc),
    .mode     (mode),
    .k        (k_c),
    .result_c (step_c)
  );

  // Control FSM with registered busy/done/illegal/result.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      mode      <= OP_SHR;
      acc       <= '0;
      count     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state     <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          if (accept_c) begin
            acc   <= bus.operand;
            mode  <= bus.op;
            count <= n_c;
            if (!legal_c || (n_c == '0)) begin
              state     <= S_DONE;
              done_q    <= 1'b1;
              illegal_q <= !legal_c;
              result_q  <= bus.operand;
            end else begin
              state  <= S_SHIFT;
              busy_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (bus.abort) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            count  <= '0;
          end else begin
            acc   <= step_c;
            count <= count - k_c;
            if (count == k_c) begin
              state    <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= step_c;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed scoreboard bench for iter_shift_unit at STEP=1 and STEP=4.
module tb_iter_shift_unit;
  import iter_shift_unit_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic        illegal;
    int          lat;
  } exp_t;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_errors;
  exp_t sb1[$];
  exp_t sb4[$];

  iter_shift_unit_if #(.DATA_WIDTH(32)) if1 ();
  iter_shift_unit_if #(.DATA_WIDTH(32)) if4 ();

  iter_shift_unit #(.DATA_WIDTH(32), .STEP(1)) u_dut1 (
    .clock (clock),
    .clear (clear),
    .bus   (if1.slave)
  );

  iter_shift_unit #(.DATA_WIDTH(32), .STEP(4)) u_dut4 (
    .clock (clock),
    .clear (clear),
    .bus   (if4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? if1.done : if4.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if1.busy : if4.busy;
  endfunction

  function automatic logic [31:0] get_result(input int sel);
    return (sel == 0) ? if1.result : if4.result;
  endfunction

  task automatic drive(input int sel, input logic st, input logic ab, input op_t o,
                       input logic [31:0] opd, input logic [31:0] amt);
    if (sel == 0) begin
      if1.start = st; if1.abort = ab; if1.op = o; if1.operand = opd; if1.amount = amt;
    end else begin
      if4.start = st; if4.abort = ab; if4.op = o; if4.operand = opd; if4.amount = amt;
    end
  endtask

  // Pulse start for one cycle; optionally record the expected outcome.
  task automatic issue(input int sel, input bit now, input op_t o, input logic [31:0] opd,
                       input logic [31:0] amt, input bit push, input logic [31:0] eres,
                       input logic eill, input int elat);
    exp_t e;
    if (!now) @(negedge clock);
    drive(sel, 1'b1, 1'b0, o, opd, amt);
    if (push) begin
      e.result = eres; e.illegal = eill; e.lat = elat;
      if (sel == 0) sb1.push_back(e); else sb4.push_back(e);
    end
    @(posedge clock);
    #1 drive(sel, 1'b0, 1'b0, o, opd, amt);
  endtask

  // Wait (bounded) for done, then compare against the oldest scoreboard entry.
  task automatic complete(input int sel, input string tag, input int pre);
    int   cyc;
    int   bcyc;
    bit   seen;
    exp_t e;
    cyc = pre; bcyc = pre; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      cyc++;
      if (get_busy(sel)) bcyc++;
      if (get_done(sel)) seen = 1'b1;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    if ((sel == 0) ? (sb1.size() == 0) : (sb4.size() == 0)) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      e = (sel == 0) ? sb1.pop_front() : sb4.pop_front();
      check({tag, ".result"},  get_result(sel), e.result);
      check({tag, ".illegal"}, 32'((sel == 0) ? if1.illegal : if4.illegal), 32'(e.illegal));
      check({tag, ".latency"}, 32'(cyc), 32'(e.lat));
      check({tag, ".busy_cycles"}, 32'(bcyc), 32'(e.lat - 1));
    end
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_errors = 0;
    clear = 1'b0;
    drive(0, 1'b0, 1'b0, OP_SHR, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, OP_SHR, 32'h0, 32'h0);
    repeat (3) @(negedge clock);
    check("reset.busy",    32'(if1.busy),    32'd0);
    check("reset.done",    32'(if1.done),    32'd0);
    check("reset.illegal", 32'(if1.illegal), 32'd0);
    check("reset.result",  if1.result,       32'd0);
    check("reset.busy4",   32'(if4.busy),    32'd0);
    check("reset.result4", if4.result,       32'd0);
    clear = 1'b1;

    // STEP=1 basic shifts, saturation and rotates
    issue(0, 0, OP_SHR, 32'h0000FF00, 32'd8, 1, 32'h000000FF, 1'b0, 9);
    complete(0, "shr8", 0);
    issue(0, 0, OP_SHRA, 32'h80000000, 32'd4, 1, 32'hF8000000, 1'b0, 5);
    complete(0, "shra4", 0);
    issue(0, 0, OP_SHRA, 32'h80000000, 32'd40, 1, 32'hFFFFFFFF, 1'b0, 33);
    complete(0, "shra40", 0);
    issue(0, 0, OP_SHL, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 32'h00000000, 1'b0, 33);
    complete(0, "shl_sat", 0);
    issue(0, 0, OP_ROL, 32'h80000001, 32'd33, 1, 32'h00000003, 1'b0, 2);
    complete(0, "rol33", 0);
    issue(0, 0, OP_ROR, 32'h00000001, 32'd0, 1, 32'h00000001, 1'b0, 1);
    complete(0, "ror0", 0);
    issue(0, 0, OP_ROR, 32'h00000001, 32'd4, 1, 32'h10000000, 1'b0, 5);
    complete(0, "ror4", 0);

    // STEP=4 multi-bit iterations and illegal opcode
    issue(1, 0, OP_SHL, 32'h0000000F, 32'd9, 1, 32'h00001E00, 1'b0, 4);
    complete(1, "s4_shl9", 0);
    issue(1, 0, OP_ROR, 32'h12345678, 32'd8, 1, 32'h78123456, 1'b0, 3);
    complete(1, "s4_ror8", 0);
    issue(1, 0, OP_SHRA, 32'h40000000, 32'd100, 1, 32'h00000000, 1'b0, 9);
    complete(1, "s4_shra_sat", 0);
    issue(1, 0, op_t'(3'd6), 32'h00001234, 32'd5, 1, 32'h00001234, 1'b1, 1);
    complete(1, "s4_illegal", 0);

    // start while busy is ignored; no extra done afterwards
    issue(0, 0, OP_SHR, 32'h000000F0, 32'd4, 1, 32'h0000000F, 1'b0, 5);
    @(negedge clock);
    drive(0, 1'b1, 1'b0, OP_SHL, 32'hFFFFFFFF, 32'd1);
    @(posedge clock);
    #1 drive(0, 1'b0, 1'b0, OP_SHL, 32'hFFFFFFFF, 32'd1);
    complete(0, "busy_start", 1);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (if1.done) dones++;
    end
    check("busy_start.no_extra_done", 32'(dones), 32'd0);

    // back-to-back: second start in the DONE cycle
    issue(0, 0, OP_SHL, 32'h00000001, 32'd2, 1, 32'h00000004, 1'b0, 3);
    complete(0, "b2b_a", 0);
    issue(0, 1, OP_SHR, 32'h00000100, 32'd4, 1, 32'h00000010, 1'b0, 5);
    complete(0, "b2b_b", 0);

    // abort mid-shift: no done, result keeps previous value
    issue(0, 0, OP_SHR, 32'hFFFFFFFF, 32'd20, 0, 32'h0, 1'b0, 0);
    repeat (3) @(negedge clock);
    drive(0, 1'b0, 1'b1, OP_SHR, 32'hFFFFFFFF, 32'd20);
    @(posedge clock);
    #1 drive(0, 1'b0, 1'b0, OP_SHR, 32'hFFFFFFFF, 32'd20);
    @(negedge clock);
    check("abort.busy",   32'(if1.busy), 32'd0);
    check("abort.result", if1.result,    32'h00000010);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (if1.done) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);

    // abort and start together in IDLE: abort wins
    @(negedge clock);
    drive(0, 1'b1, 1'b1, OP_SHL, 32'h00000001, 32'd3);
    @(posedge clock);
    #1 drive(0, 1'b0, 1'b0, OP_SHL, 32'h00000001, 32'd3);
    @(negedge clock);
    check("abort_start.busy", 32'(if1.busy), 32'd0);
    check("abort_start.done", 32'(if1.done), 32'd0);

    // asynchronous clear mid-shift
    issue(0, 0, OP_SHRA, 32'h80000000, 32'd20, 0, 32'h0, 1'b0, 0);
    repeat (3) @(negedge clock);
    clear = 1'b0;
    #1;
    check("clear.busy",    32'(if1.busy), 32'd0);
    check("clear.done",    32'(if1.done), 32'd0);
    check("clear.result",  if1.result,    32'd0);
    check("clear.result4", if4.result,    32'd0);
    @(negedge clock);
    clear = 1'b1;
    issue(0, 0, OP_SHR, 32'h0000FF00, 32'd8, 1, 32'h000000FF, 1'b0, 9);
    complete(0, "after_clear", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
